morse_tone_sequencer: RTL

//  Plays queued Morse symbols on the shared piezo and red LED with standard unit timing.

---
 rtl/morse_tone_sequencer_pkg.sv | 34 +++
 rtl/morse_tone_sequencer_sym_fifo.sv | 52 +++++
 rtl/morse_tone_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/morse_tone_sequencer_pkg.sv
// Shared Morse symbol codes, unit counts and FSM state encodings.
package morse_tone_sequencer_pkg;

  localparam logic [1:0] SYM_DIT  = 2'b00;
  localparam logic [1:0] SYM_DAH  = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [2:0] DIT_UNITS   = 3'd1;
  localparam logic [2:0] DAH_UNITS   = 3'd3;
  localparam logic [2:0] LGAP_UNITS  = 3'd2;
  localparam logic [2:0] WGAP_UNITS  = 3'd6;
  localparam logic [2:0] SPACE_UNITS = 3'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Number of units a symbol occupies once it is loaded into the player.
  function automatic logic [2:0] sym_units(input logic [1:0] sym);
    case (sym)
      SYM_DIT:  return DIT_UNITS;
      SYM_DAH:  return DAH_UNITS;
      SYM_LGAP: return LGAP_UNITS;
      SYM_WGAP: return WGAP_UNITS;
      default:  return WGAP_UNITS;
    endcase
  endfunction

  function automatic logic sym_is_tone(input logic [1:0] sym);
    return (sym == SYM_DIT) || (sym == SYM_DAH);
  endfunction

endpackage

// File: rtl/morse_tone_sequencer_sym_fifo.sv
// Synchronous DEPTH x 2-bit symbol FIFO with occupancy count and flush.
module morse_sym_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [1:0]               push_data,
  input  logic                     pop,
  output logic [1:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & !full;
  assign pop_ok   = pop & !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/morse_tone_sequencer.sv
// Plays queued Morse symbols on the piezo and red LED with unit timing.
module morse_tone_sequencer
  import morse_tone_sequencer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int UNIT_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [1:0]  sym_data,
  output logic        sym_ready,
  input  logic [31:0] tone_freq,
  input  logic        mute,
  input  logic        abort,
  output logic        piezo_en,
  output logic [31:0] piezo_freq,
  output logic        led_red_en,
  output logic        busy,
  output logic        done
);
  localparam int UW = $clog2(UNIT_CYCLES);

  logic [1:0]              state;
  logic [2:0]              units_left;
  logic [UW-1:0]           unit_cnt;
  logic [1:0]              head_sym;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    unit_end;
  logic                    last_unit;

  assign sym_ready = !fifo_full;
  assign push      = sym_valid & sym_ready & !abort;
  assign unit_end  = (unit_cnt == UW'(UNIT_CYCLES - 1));
  assign last_unit = unit_end && (units_left == 3'd1);
  // Pop from IDLE, or on the final edge of a gap so symbols chain without an idle cycle.
  assign pop = !abort && !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_GAP) && last_unit));

  morse_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (sym_data),
    .pop       (pop),
    .pop_data  (head_sym),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Player FSM: element/gap timing, tone frequency latch and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      units_left <= '0;
      unit_cnt   <= '0;
      piezo_freq <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      units_left <= '0;
      unit_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        state      <= sym_is_tone(head_sym) ? ST_TONE : ST_GAP;
        units_left <= sym_units(head_sym);
        unit_cnt   <= '0;
        if (sym_is_tone(head_sym)) piezo_freq <= tone_freq;
      end else begin
        case (state)
          ST_TONE: begin
            if (unit_end) begin
              unit_cnt <= '0;
              if (units_left == 3'd1) begin
                state      <= ST_GAP;
                units_left <= SPACE_UNITS;
              end else begin
                units_left <= units_left - 3'd1;
              end
            end else begin
              unit_cnt <= unit_cnt + UW'(1);
            end
          end
          ST_GAP: begin
            if (unit_end) begin
              unit_cnt <= '0;
              if (units_left == 3'd1) begin
                state      <= ST_IDLE;
                units_left <= '0;
                done       <= 1'b1;
              end else begin
                units_left <= units_left - 3'd1;
              end
            end else begin
              unit_cnt <= unit_cnt + UW'(1);
            end
          end
          default: begin
            state      <= ST_IDLE;
            units_left <= '0;
            unit_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign led_red_en = (state == ST_TONE);
  assign piezo_en   = (state == ST_TONE) & !mute;
  assign busy       = (state != ST_IDLE) | (fifo_count != '0);
endmodule
